// File: rtl/sim_finisher_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sim_finisher_pkg : register map, reason codes and state types
// Rev 1.0
// ---------------------------------------------------------------------------
package sim_finisher_pkg;

   localparam logic [7:0] ADDR_CTRL      = 8'h00;
   localparam logic [7:0] ADDR_MASK      = 8'h04;
   localparam logic [7:0] ADDR_WDOG_LOAD = 8'h08;
   localparam logic [7:0] ADDR_KICK      = 8'h0C;
   localparam logic [7:0] ADDR_STATUS    = 8'h10;
   localparam logic [7:0] ADDR_RESULT    = 8'h40;
   localparam logic [7:0] ADDR_CYCLE_LO  = 8'h44;
   localparam logic [7:0] ADDR_CYCLE_HI  = 8'h48;

   localparam logic [1:0] REASON_PASS    = 2'd0;
   localparam logic [1:0] REASON_FAIL    = 2'd1;
   localparam logic [1:0] REASON_TIMEOUT = 2'd2;

   typedef enum logic [1:0] {CH_IDLE = 2'd0, CH_PASS = 2'd1, CH_FAIL = 2'd2} ch_state_t;
   typedef enum logic {ST_RUN = 1'b0, ST_FINISHED = 1'b1} glb_state_t;

endpackage
`default_nettype wire

// File: rtl/sim_finisher_wdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sim_finisher_wdog : reloadable saturating down-counter with zero flag
// Rev 1.0
// ---------------------------------------------------------------------------
module sim_finisher_wdog #(
   parameter int WDOG_W       = 32,
   parameter int WDOG_DEFAULT = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WDOG_W-1:0] load_val,
   input  logic              kick,
   input  logic              dec_en,
   output logic              zero
);

   localparam logic [WDOG_W-1:0] RELOAD_RST = WDOG_W'(WDOG_DEFAULT);

   logic [WDOG_W-1:0] reload_q;
   logic [WDOG_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reload_q <= RELOAD_RST;
         count_q  <= RELOAD_RST;
      end else if (load) begin
         reload_q <= load_val;
         count_q  <= load_val;
      end else if (kick) begin
         count_q <= reload_q;
      end else if (dec_en && (count_q != '0)) begin
         count_q <= count_q - WDOG_W'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sim_test_finisher.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sim_test_finisher : bus-mapped pass/fail/timeout aggregator driving sim_finish
// Rev 1.0
// ---------------------------------------------------------------------------
module sim_test_finisher
   import sim_finisher_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int WDOG_W       = 32,
   parameter int WDOG_DEFAULT = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [7:0]        req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              sim_finish,
   output logic              sim_pass,
   output logic [1:0]        finish_reason,
   output logic [2:0]        fail_chan,
   output logic [15:0]       fail_code,
   output logic [NUM_CH-1:0] chan_done
);

   glb_state_t        state_q, state_d;
   logic [1:0]        reason_q, reason_d;
   logic              pass_q, pass_d;
   logic [2:0]        fchan_q, fchan_d;
   logic [15:0]       fcode_q, fcode_d;
   logic [1:0]        ctrl_q;
   logic [NUM_CH-1:0] mask_q;
   logic [63:0]       cycle_q;
   logic [31:0]       hi_snap_q;

   ch_state_t         ch_state [NUM_CH];
   ch_state_t         ch_next  [NUM_CH];
   logic [15:0]       ch_code  [NUM_CH];
   logic [NUM_CH-1:0] ch_wr, done_vec, fail_vec, m_fail, m_done;

   logic [7:0]  word_addr;
   logic        wr_acc, rd_acc, running, cfg_wr;
   logic        status_hit;
   logic [3:0]  status_idx;
   logic        sel_hit, sel_done, sel_pass;
   logic [15:0] sel_code;
   logic        any_fail, all_done, fail_ev, tmo_ev, pass_ev;
   logic [2:0]  low_chan;
   logic [15:0] low_code;
   logic        wd_load, wd_kick, wd_zero;
   logic [31:0] rd_data;
   logic        unused_addr_bits;

   assign req_ready        = 1'b1;
   assign unused_addr_bits = ^req_addr[1:0];
   assign word_addr        = {req_addr[7:2], 2'b00};
   assign wr_acc           = req_valid & req_write;
   assign rd_acc           = req_valid & ~req_write;
   assign running          = (state_q == ST_RUN);
   // Once finished, every write is acknowledged but dropped.
   assign cfg_wr           = running & wr_acc;
   assign status_hit       = (req_addr[7:6] == 2'b00) && (req_addr[5:4] != 2'b00);
   assign status_idx       = req_addr[5:2] - 4'd4;

   always_comb begin
      sel_hit  = 1'b0;
      sel_done = 1'b0;
      sel_pass = 1'b0;
      sel_code = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         ch_wr[k]    = cfg_wr && status_hit && (status_idx == 4'(k)) && req_wdata[0];
         done_vec[k] = (ch_state[k] != CH_IDLE);
         fail_vec[k] = (ch_state[k] == CH_FAIL);
         ch_next[k]  = ch_state[k];
         if (ch_wr[k] && (ch_state[k] == CH_IDLE))
            ch_next[k] = req_wdata[1] ? CH_PASS : CH_FAIL;
         if (status_hit && (status_idx == 4'(k))) begin
            sel_hit  = 1'b1;
            sel_done = (ch_state[k] != CH_IDLE);
            sel_pass = (ch_state[k] == CH_PASS);
            sel_code = ch_code[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            ch_state[k] <= CH_IDLE;
            ch_code[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            ch_state[k] <= ch_next[k];
            if (ch_wr[k] && (ch_state[k] == CH_IDLE))
               ch_code[k] <= req_wdata[31:16];
         end
      end
   end

   assign m_fail   = fail_vec & mask_q;
   assign m_done   = done_vec & mask_q;
   assign any_fail = |m_fail;
   assign all_done = (m_done == mask_q) && (|mask_q);

   // Descending scan leaves the lowest failing index selected.
   always_comb begin
      low_chan = '0;
      low_code = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (m_fail[k]) begin
            low_chan = 3'(k);
            low_code = ch_code[k];
         end
      end
   end

   assign wd_load = cfg_wr && (word_addr == ADDR_WDOG_LOAD);
   assign wd_kick = cfg_wr && (word_addr == ADDR_KICK);

   sim_finisher_wdog #(
      .WDOG_W       (WDOG_W),
      .WDOG_DEFAULT (WDOG_DEFAULT)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .load     (wd_load),
      .load_val (req_wdata[WDOG_W-1:0]),
      .kick     (wd_kick),
      .dec_en   (running & ctrl_q[0]),
      .zero     (wd_zero)
   );

   // A reload accepted in the zero cycle rescues the run.
   assign fail_ev = any_fail && (ctrl_q[1] || all_done);
   assign tmo_ev  = ctrl_q[0] && wd_zero && !(wd_load || wd_kick);
   assign pass_ev = all_done && !any_fail;

   always_comb begin
      state_d  = state_q;
      reason_d = reason_q;
      pass_d   = pass_q;
      fchan_d  = fchan_q;
      fcode_d  = fcode_q;
      if (running) begin
         if (fail_ev) begin
            state_d  = ST_FINISHED;
            reason_d = REASON_FAIL;
            fchan_d  = low_chan;
            fcode_d  = low_code;
         end else if (tmo_ev) begin
            state_d  = ST_FINISHED;
            reason_d = REASON_TIMEOUT;
         end else if (pass_ev) begin
            state_d  = ST_FINISHED;
            reason_d = REASON_PASS;
            pass_d   = 1'b1;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (word_addr)
         ADDR_CTRL:     rd_data = {30'b0, ctrl_q};
         ADDR_MASK:     rd_data[NUM_CH-1:0] = mask_q;
         ADDR_RESULT:   rd_data = {fcode_q, 5'b0, fchan_q, 2'b0, reason_q, 2'b0, pass_q, sim_finish};
         ADDR_CYCLE_LO: rd_data = cycle_q[31:0];
         ADDR_CYCLE_HI: rd_data = hi_snap_q;
         default:       if (sel_hit) rd_data = {sel_code, 14'b0, sel_pass, sel_done};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         reason_q   <= '0;
         pass_q     <= 1'b0;
         fchan_q    <= '0;
         fcode_q    <= '0;
         ctrl_q     <= '0;
         mask_q     <= '1;
         cycle_q    <= '0;
         hi_snap_q  <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state_q    <= state_d;
         reason_q   <= reason_d;
         pass_q     <= pass_d;
         fchan_q    <= fchan_d;
         fcode_q    <= fcode_d;
         resp_valid <= req_valid;
         resp_rdata <= rd_acc ? rd_data : '0;
         if (cfg_wr && (word_addr == ADDR_CTRL)) ctrl_q <= req_wdata[1:0];
         if (cfg_wr && (word_addr == ADDR_MASK)) mask_q <= req_wdata[NUM_CH-1:0];
         if (running) cycle_q <= cycle_q + 64'd1;
         if (rd_acc && (word_addr == ADDR_CYCLE_LO)) hi_snap_q <= cycle_q[63:32];
      end
   end

   assign sim_finish    = (state_q == ST_FINISHED);
   assign sim_pass      = pass_q;
   assign finish_reason = reason_q;
   assign fail_chan     = fchan_q;
   assign fail_code     = fcode_q;
   assign chan_done     = done_vec;

endmodule
`default_nettype wire
